// File: rtl/ring_sequence_checker.sv
// ring_sequence_checker: receive-side monitor for a one-hot ring counter bus.
// It hunts for a run of correctly rotated samples and then locks. While locked,
// it checks every sample against the expected rotation. It also decodes the
// active bit position and keeps a saturating count of mismatches.
//
// state  | meaning
// HUNT   | searching for LOCK_CNT consecutive legal, correctly rotated samples
// LOCKED | tracking the ring; mismatches pulse err and advance a flywheel
module ring_sequence_checker #(
  parameter int WIDTH    = 4,
  parameter int IDX_W    = 2,
  parameter int LOCK_CNT = 3,
  parameter int LOSS_CNT = 2,
  parameter int ERRW     = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] ring_in,
  input  logic             valid,
  output logic             locked,
  output logic [IDX_W-1:0] index,
  output logic             err,
  output logic [ERRW-1:0]  err_count
);

  localparam int RUN_W  = $clog2(LOCK_CNT + 1);
  localparam int MISS_W = $clog2(LOSS_CNT + 1);

  typedef enum logic {HUNT, LOCKED} state_t;

  state_t            state;
  logic [WIDTH-1:0]  prev;
  logic [RUN_W-1:0]  run;
  logic [MISS_W-1:0] miss;

  logic              legal;
  logic              match;
  logic [WIDTH-1:0]  exp_next;
  logic [IDX_W-1:0]  sample_idx;
  logic [RUN_W-1:0]  run_inc;
  logic [MISS_W-1:0] miss_inc;

  // Decode the sample: legality, bit position, and comparison with rot(prev)
  always_comb begin
    legal      = ($countones(ring_in) == 1);
    exp_next   = {prev[WIDTH-2:0], prev[WIDTH-1]};
    match      = (ring_in == exp_next);
    run_inc    = run + 1'b1;
    miss_inc   = miss + 1'b1;
    sample_idx = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (ring_in[i]) sample_idx = IDX_W'(i);
    end
  end

  // Lock FSM with registered outputs; each output reflects the sample taken on this edge
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= HUNT;
      locked    <= 1'b0;
      index     <= '0;
      err       <= 1'b0;
      err_count <= '0;
      prev      <= '0;
      run       <= '0;
      miss      <= '0;
    end else if (valid) begin
      err <= 1'b0;
      if (legal) index <= sample_idx;
      case (state)
        HUNT: begin
          if (!legal) begin
            run <= '0;
          end else begin
            prev <= ring_in;
            if (run != '0 && match) begin
              run <= run_inc;
              if (run_inc == RUN_W'(LOCK_CNT)) begin
                state  <= LOCKED;
                locked <= 1'b1;
                miss   <= '0;
              end
            end else begin
              run <= RUN_W'(1);
            end
          end
        end
        LOCKED: begin
          if (match) begin
            prev <= ring_in;
            miss <= '0;
          end else begin
            // Flywheel: keep advancing so one corrupted sample does not misalign us
            err  <= 1'b1;
            prev <= exp_next;
            miss <= miss_inc;
            if (err_count != '1) err_count <= err_count + 1'b1;
            if (miss_inc == MISS_W'(LOSS_CNT)) begin
              state  <= HUNT;
              locked <= 1'b0;
              run    <= '0;
            end
          end
        end
        default: state <= HUNT;
      endcase
    end else begin
      err <= 1'b0;
    end
  end

endmodule
